// File: rtl/rs_bank.sv
// rs_bank: multi-entry reservation station with CDB operand wakeup and oldest-first issue.
// Latency: dispatch or CDB broadcast -> issue-eligible on the next cycle; issue outputs are combinational.
// Backpressure: an issued entry is held until issue_ready; dispatch lanes beyond free_slots are dropped.
module rs_bank #(
    parameter int RS_SIZE   = 16,
    parameter int WAYS      = 3,
    parameter int ISSUE_W   = 2,
    parameter int XLEN      = 32,
    parameter int PRF       = 64,
    parameter int ROB       = 16,
    parameter int PAYLOAD_W = 64,
    localparam int PRF_W    = $clog2(PRF),
    localparam int ROB_W    = $clog2(ROB),
    localparam int FS_W     = $clog2(RS_SIZE + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic [WAYS-1:0]              cdb_valid,
    input  logic [WAYS*PRF_W-1:0]        cdb_prf_idx,
    input  logic [WAYS*XLEN-1:0]         cdb_data,
    input  logic [WAYS-1:0]              dispatch_valid,
    input  logic [WAYS-1:0]              dispatch_opa_valid,
    input  logic [WAYS-1:0]              dispatch_opb_valid,
    input  logic [WAYS*XLEN-1:0]         dispatch_opa,
    input  logic [WAYS*XLEN-1:0]         dispatch_opb,
    input  logic [WAYS*PRF_W-1:0]        dispatch_dest_prf,
    input  logic [WAYS*ROB_W-1:0]        dispatch_rob_idx,
    input  logic [WAYS*PAYLOAD_W-1:0]    dispatch_payload,
    output logic [WAYS-1:0]              dispatch_accepted,
    output logic [FS_W-1:0]              free_slots,
    output logic [ISSUE_W-1:0]           issue_valid,
    input  logic [ISSUE_W-1:0]           issue_ready,
    output logic [ISSUE_W*XLEN-1:0]      issue_opa,
    output logic [ISSUE_W*XLEN-1:0]      issue_opb,
    output logic [ISSUE_W*PRF_W-1:0]     issue_dest_prf,
    output logic [ISSUE_W*ROB_W-1:0]     issue_rob_idx,
    output logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload
);

    // Registered entry state
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RS_SIZE-1:0]   opa_rdy_q, opa_rdy_d;
    logic [RS_SIZE-1:0]   opb_rdy_q, opb_rdy_d;
    logic [XLEN-1:0]      opa_q [RS_SIZE];
    logic [XLEN-1:0]      opa_d [RS_SIZE];
    logic [XLEN-1:0]      opb_q [RS_SIZE];
    logic [XLEN-1:0]      opb_d [RS_SIZE];
    logic [PRF_W-1:0]     dest_q [RS_SIZE];
    logic [PRF_W-1:0]     dest_d [RS_SIZE];
    logic [ROB_W-1:0]     rob_q [RS_SIZE];
    logic [ROB_W-1:0]     rob_d [RS_SIZE];
    logic [PAYLOAD_W-1:0] payload_q [RS_SIZE];
    logic [PAYLOAD_W-1:0] payload_d [RS_SIZE];
    // older_q[i][j]: entry i was allocated before entry j
    logic [RS_SIZE-1:0]   older_q [RS_SIZE];
    logic [RS_SIZE-1:0]   older_d [RS_SIZE];
    logic [FS_W-1:0]      free_slots_q, free_slots_d;

    // Issue-side combinational signals
    logic [RS_SIZE-1:0]   ready;
    logic [FS_W-1:0]      rank [RS_SIZE];
    logic [RS_SIZE-1:0]   freed;
    logic [FS_W-1:0]      num_issued;

    // Dispatch-side combinational signals
    logic [WAYS-1:0]      accepted;
    logic [FS_W-1:0]      num_accepted;
    logic [FS_W-1:0]      vcnt;
    logic [FS_W-1:0]      fcnt;
    logic [FS_W-1:0]      lane_slot [WAYS];
    logic [FS_W-1:0]      free_rank [RS_SIZE];
    logic [RS_SIZE-1:0]   alloc_hit [WAYS];
    logic [RS_SIZE-1:0]   later_mask [WAYS];
    logic [RS_SIZE-1:0]   alloc;
    logic [XLEN-1:0]      disp_opa [WAYS];
    logic [XLEN-1:0]      disp_opb [WAYS];
    logic [WAYS-1:0]      disp_opa_rdy;
    logic [WAYS-1:0]      disp_opb_rdy;

    assign free_slots        = free_slots_q;
    assign dispatch_accepted = accepted;

    // Rank each ready entry by how many ready entries are older; port p takes rank p
    always_comb begin
        ready = busy_q & opa_rdy_q & opb_rdy_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            rank[i] = '0;
            for (int j = 0; j < RS_SIZE; j++) begin
                if (ready[j] && older_q[j][i]) rank[i] = rank[i] + 1'b1;
            end
        end
        freed          = '0;
        num_issued     = '0;
        issue_valid    = '0;
        issue_opa      = '0;
        issue_opb      = '0;
        issue_dest_prf = '0;
        issue_rob_idx  = '0;
        issue_payload  = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ready[i] && rank[i] == FS_W'(p)) begin
                    issue_valid[p]                         = 1'b1;
                    issue_opa[p*XLEN +: XLEN]              = opa_q[i];
                    issue_opb[p*XLEN +: XLEN]              = opb_q[i];
                    issue_dest_prf[p*PRF_W +: PRF_W]       = dest_q[i];
                    issue_rob_idx[p*ROB_W +: ROB_W]        = rob_q[i];
                    issue_payload[p*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
                    if (issue_ready[p]) freed[i] = 1'b1;
                end
            end
            if (issue_valid[p] && issue_ready[p]) num_issued = num_issued + 1'b1;
        end
    end

    // Lane acceptance, slot allocation (lowest free entries in lane order) and CDB bypass
    always_comb begin
        vcnt         = '0;
        num_accepted = '0;
        accepted     = '0;
        for (int k = 0; k < WAYS; k++) begin
            lane_slot[k] = num_accepted;
            if (dispatch_valid[k] && !reset && !squash && vcnt < free_slots_q) begin
                accepted[k]  = 1'b1;
                num_accepted = num_accepted + 1'b1;
            end
            if (dispatch_valid[k]) vcnt = vcnt + 1'b1;
        end

        fcnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_rank[i] = fcnt;
            if (!busy_q[i]) fcnt = fcnt + 1'b1;
        end

        alloc = '0;
        for (int k = 0; k < WAYS; k++) begin
            alloc_hit[k] = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (accepted[k] && !busy_q[i] && free_rank[i] == lane_slot[k]) alloc_hit[k][i] = 1'b1;
            end
            alloc = alloc | alloc_hit[k];
        end

        for (int k = 0; k < WAYS; k++) begin
            later_mask[k] = '0;
            for (int m = k + 1; m < WAYS; m++) later_mask[k] = later_mask[k] | alloc_hit[m];
        end

        // Descending channel scan so the lowest matching channel overrides
        for (int k = 0; k < WAYS; k++) begin
            disp_opa[k]     = dispatch_opa[k*XLEN +: XLEN];
            disp_opb[k]     = dispatch_opb[k*XLEN +: XLEN];
            disp_opa_rdy[k] = dispatch_opa_valid[k];
            disp_opb_rdy[k] = dispatch_opb_valid[k];
            for (int c = WAYS - 1; c >= 0; c--) begin
                if (!dispatch_opa_valid[k] && cdb_valid[c] &&
                    cdb_prf_idx[c*PRF_W +: PRF_W] == dispatch_opa[k*XLEN +: PRF_W]) begin
                    disp_opa_rdy[k] = 1'b1;
                    disp_opa[k]     = cdb_data[c*XLEN +: XLEN];
                end
                if (!dispatch_opb_valid[k] && cdb_valid[c] &&
                    cdb_prf_idx[c*PRF_W +: PRF_W] == dispatch_opb[k*XLEN +: PRF_W]) begin
                    disp_opb_rdy[k] = 1'b1;
                    disp_opb[k]     = cdb_data[c*XLEN +: XLEN];
                end
            end
        end
    end

    // Next entry state: free on issue, write on allocation, wake up waiting operands; squash clears all
    always_comb begin
        busy_d    = busy_q;
        opa_rdy_d = opa_rdy_q;
        opb_rdy_d = opb_rdy_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        dest_d    = dest_q;
        rob_d     = rob_q;
        payload_d = payload_q;
        older_d   = older_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (freed[i]) begin
                busy_d[i]    = 1'b0;
                opa_rdy_d[i] = 1'b0;
                opb_rdy_d[i] = 1'b0;
                older_d[i]   = '0;
            end else if (alloc[i]) begin
                busy_d[i] = 1'b1;
                for (int k = 0; k < WAYS; k++) begin
                    if (alloc_hit[k][i]) begin
                        opa_rdy_d[i] = disp_opa_rdy[k];
                        opb_rdy_d[i] = disp_opb_rdy[k];
                        opa_d[i]     = disp_opa[k];
                        opb_d[i]     = disp_opb[k];
                        dest_d[i]    = dispatch_dest_prf[k*PRF_W +: PRF_W];
                        rob_d[i]     = dispatch_rob_idx[k*ROB_W +: ROB_W];
                        payload_d[i] = dispatch_payload[k*PAYLOAD_W +: PAYLOAD_W];
                        // New entry is older only than entries allocated by later lanes
                        older_d[i]   = later_mask[k];
                    end
                end
            end else if (busy_q[i]) begin
                for (int c = WAYS - 1; c >= 0; c--) begin
                    if (!opa_rdy_q[i] && cdb_valid[c] &&
                        cdb_prf_idx[c*PRF_W +: PRF_W] == opa_q[i][PRF_W-1:0]) begin
                        opa_rdy_d[i] = 1'b1;
                        opa_d[i]     = cdb_data[c*XLEN +: XLEN];
                    end
                    if (!opb_rdy_q[i] && cdb_valid[c] &&
                        cdb_prf_idx[c*PRF_W +: PRF_W] == opb_q[i][PRF_W-1:0]) begin
                        opb_rdy_d[i] = 1'b1;
                        opb_d[i]     = cdb_data[c*XLEN +: XLEN];
                    end
                end
                // Surviving entries drop freed columns and become older than every new allocation
                older_d[i] = (older_q[i] & ~freed) | alloc;
            end else begin
                older_d[i] = '0;
            end
        end
        if (squash) begin
            busy_d    = '0;
            opa_rdy_d = '0;
            opb_rdy_d = '0;
            for (int i = 0; i < RS_SIZE; i++) older_d[i] = '0;
        end
        free_slots_d = squash ? FS_W'(RS_SIZE) : free_slots_q - num_accepted + num_issued;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            opa_rdy_q    <= '0;
            opb_rdy_q    <= '0;
            free_slots_q <= FS_W'(RS_SIZE);
            for (int i = 0; i < RS_SIZE; i++) begin
                opa_q[i]     <= '0;
                opb_q[i]     <= '0;
                dest_q[i]    <= '0;
                rob_q[i]     <= '0;
                payload_q[i] <= '0;
                older_q[i]   <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            opa_rdy_q    <= opa_rdy_d;
            opb_rdy_q    <= opb_rdy_d;
            free_slots_q <= free_slots_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            dest_q       <= dest_d;
            rob_q        <= rob_d;
            payload_q    <= payload_d;
            older_q      <= older_d;
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: drives directed and random traffic into rs_bank; a queue-based age-ordered
// model predicts each cycle's outputs, which a separate monitor compares at the falling edge.
module tb_rs_bank;
    localparam int RS  = 16;
    localparam int W   = 3;
    localparam int IW  = 2;
    localparam int XL  = 32;
    localparam int PW  = 6;
    localparam int RW  = 4;
    localparam int PL  = 64;
    localparam int FSW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic [W-1:0]      cdb_valid;
    logic [W*PW-1:0]   cdb_prf_idx;
    logic [W*XL-1:0]   cdb_data;
    logic [W-1:0]      dispatch_valid, dispatch_opa_valid, dispatch_opb_valid;
    logic [W*XL-1:0]   dispatch_opa, dispatch_opb;
    logic [W*PW-1:0]   dispatch_dest_prf;
    logic [W*RW-1:0]   dispatch_rob_idx;
    logic [W*PL-1:0]   dispatch_payload;
    logic [W-1:0]      dispatch_accepted;
    logic [FSW-1:0]    free_slots;
    logic [IW-1:0]     issue_valid, issue_ready;
    logic [IW*XL-1:0]  issue_opa, issue_opb;
    logic [IW*PW-1:0]  issue_dest_prf;
    logic [IW*RW-1:0]  issue_rob_idx;
    logic [IW*PL-1:0]  issue_payload;

    always #5 clock = ~clock;

    rs_bank dut (
        .clock(clock), .reset(reset), .squash(squash),
        .cdb_valid(cdb_valid), .cdb_prf_idx(cdb_prf_idx), .cdb_data(cdb_data),
        .dispatch_valid(dispatch_valid), .dispatch_opa_valid(dispatch_opa_valid),
        .dispatch_opb_valid(dispatch_opb_valid), .dispatch_opa(dispatch_opa),
        .dispatch_opb(dispatch_opb), .dispatch_dest_prf(dispatch_dest_prf),
        .dispatch_rob_idx(dispatch_rob_idx), .dispatch_payload(dispatch_payload),
        .dispatch_accepted(dispatch_accepted), .free_slots(free_slots),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opa(issue_opa), .issue_opb(issue_opb), .issue_dest_prf(issue_dest_prf),
        .issue_rob_idx(issue_rob_idx), .issue_payload(issue_payload)
    );

    typedef struct packed {
        logic                 sq;
        logic [W-1:0]         dv, dav, dbv, cv;
        logic [IW-1:0]        ir;
        logic [W-1:0][XL-1:0] da, db, cd;
        logic [W-1:0][PW-1:0] dd, ct;
        logic [W-1:0][RW-1:0] dr;
        logic [W-1:0][PL-1:0] dp;
    } stim_t;

    typedef struct packed {
        logic          ra, rb;
        logic [XL-1:0] opa, opb;
        logic [PW-1:0] dest;
        logic [RW-1:0] rob;
        logic [PL-1:0] pay;
    } ent_t;

    typedef struct packed {
        logic [W-1:0]          acc;
        logic [FSW-1:0]        free;
        logic [IW-1:0]         iv;
        logic [IW-1:0][XL-1:0] opa, opb;
        logic [IW-1:0][PW-1:0] dest;
        logic [IW-1:0][RW-1:0] rob;
        logic [IW-1:0][PL-1:0] pay;
    } exp_t;

    ent_t m_q[$];     // model: live entries, oldest first
    exp_t exp_q[$];   // scoreboard of per-cycle expected outputs
    exp_t me;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Resolve a waiting operand against the CDB; lowest channel wins
    function automatic logic [XL:0] wake(input logic rdy, input logic [XL-1:0] v, input stim_t s);
        if (rdy) return {1'b1, v};
        for (int c = 0; c < W; c++)
            if (s.cv[c] && s.ct[c] == v[PW-1:0]) return {1'b1, s.cd[c]};
        return {1'b0, v};
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t lane(input stim_t s0, input int k, input logic [XL-1:0] a,
                                   input logic av, input logic [XL-1:0] b, input logic bv);
        stim_t s = s0;
        s.dv[k] = 1'b1; s.dav[k] = av; s.dbv[k] = bv;
        s.da[k] = a; s.db[k] = b;
        s.dd[k] = PW'(k + 10); s.dr[k] = RW'(k + 3); s.dp[k] = {a, b};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = '0;
        int t0, t1, t2;
        s.sq  = ($urandom_range(0, 59) == 0);
        s.dv  = W'($urandom); s.dav = W'($urandom); s.dbv = W'($urandom);
        s.cv  = W'($urandom); s.ir  = IW'($urandom);
        t0 = int'($urandom_range(0, 15));
        t1 = (t0 + 1 + int'($urandom_range(0, 4))) % 16;
        t2 = (t1 + 1 + int'($urandom_range(0, 4))) % 16;
        s.ct[0] = PW'(t0); s.ct[1] = PW'(t1); s.ct[2] = PW'(t2);
        for (int k = 0; k < W; k++) begin
            s.da[k] = s.dav[k] ? XL'($urandom) : XL'($urandom_range(0, 15));
            s.db[k] = s.dbv[k] ? XL'($urandom) : XL'($urandom_range(0, 15));
            s.cd[k] = XL'($urandom);
            s.dd[k] = PW'($urandom); s.dr[k] = RW'($urandom);
            s.dp[k] = {32'($urandom), 32'($urandom)};
        end
        return s;
    endfunction

    // One clock: drive inputs, queue the prediction, then advance the model across the edge
    task automatic cycle(input stim_t s);
        exp_t e;
        ent_t t;
        logic [XL:0] r;
        int idx[$];
        int nv;
        squash = s.sq; cdb_valid = s.cv; issue_ready = s.ir;
        dispatch_valid = s.dv; dispatch_opa_valid = s.dav; dispatch_opb_valid = s.dbv;
        for (int k = 0; k < W; k++) begin
            cdb_prf_idx[k*PW +: PW]       = s.ct[k];
            cdb_data[k*XL +: XL]          = s.cd[k];
            dispatch_opa[k*XL +: XL]      = s.da[k];
            dispatch_opb[k*XL +: XL]      = s.db[k];
            dispatch_dest_prf[k*PW +: PW] = s.dd[k];
            dispatch_rob_idx[k*RW +: RW]  = s.dr[k];
            dispatch_payload[k*PL +: PL]  = s.dp[k];
        end
        e = '0;
        e.free = FSW'(RS - m_q.size());
        nv = 0;
        for (int k = 0; k < W; k++) begin
            if (s.dv[k]) begin
                if (!s.sq && nv < RS - m_q.size()) e.acc[k] = 1'b1;
                nv++;
            end
        end
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].ra && m_q[i].rb && idx.size() < IW) idx.push_back(i);
        for (int p = 0; p < idx.size(); p++) begin
            e.iv[p] = 1'b1; e.opa[p] = m_q[idx[p]].opa; e.opb[p] = m_q[idx[p]].opb;
            e.dest[p] = m_q[idx[p]].dest; e.rob[p] = m_q[idx[p]].rob; e.pay[p] = m_q[idx[p]].pay;
        end
        exp_q.push_back(e);
        @(posedge clock);
        if (s.sq) begin
            m_q.delete();
        end else begin
            for (int p = idx.size() - 1; p >= 0; p--)
                if (s.ir[p]) m_q.delete(idx[p]);
            for (int i = 0; i < m_q.size(); i++) begin
                t = m_q[i];
                r = wake(t.ra, t.opa, s); t.ra = r[XL]; t.opa = r[XL-1:0];
                r = wake(t.rb, t.opb, s); t.rb = r[XL]; t.opb = r[XL-1:0];
                m_q[i] = t;
            end
            for (int k = 0; k < W; k++) begin
                if (e.acc[k]) begin
                    t = '0;
                    r = wake(s.dav[k], s.da[k], s); t.ra = r[XL]; t.opa = r[XL-1:0];
                    r = wake(s.dbv[k], s.db[k], s); t.rb = r[XL]; t.opb = r[XL-1:0];
                    t.dest = s.dd[k]; t.rob = s.dr[k]; t.pay = s.dp[k];
                    m_q.push_back(t);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; squash = 1'b0; dispatch_valid = '1;
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_free_slots", free_slots, RS);
        chk("rst_accepted", dispatch_accepted, 0);
        m_q.delete();
        @(posedge clock); #1;
        reset = 1'b0; dispatch_valid = '0;
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued prediction
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                me = exp_q.pop_front();
                chk("dispatch_accepted", dispatch_accepted, me.acc);
                chk("free_slots", free_slots, me.free);
                chk("issue_valid", issue_valid, me.iv);
                for (int p = 0; p < IW; p++) begin
                    if (me.iv[p]) begin
                        chk("issue_opa", issue_opa[p*XL +: XL], me.opa[p]);
                        chk("issue_opb", issue_opb[p*XL +: XL], me.opb[p]);
                        chk("issue_dest_prf", issue_dest_prf[p*PW +: PW], me.dest[p]);
                        chk("issue_rob_idx", issue_rob_idx[p*RW +: RW], me.rob[p]);
                        chk("issue_payload", issue_payload[p*PL +: PL], me.pay[p]);
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; squash = 1'b0; cdb_valid = '0; cdb_prf_idx = '0; cdb_data = '0;
        dispatch_valid = '1; dispatch_opa_valid = '0; dispatch_opb_valid = '0;
        dispatch_opa = '0; dispatch_opb = '0; dispatch_dest_prf = '0;
        dispatch_rob_idx = '0; dispatch_payload = '0; issue_ready = '0;
        #2;
        chk("reset_issue_valid", issue_valid, 0);
        chk("reset_free_slots", free_slots, RS);
        chk("reset_accepted", dispatch_accepted, 0);
        chk("reset_issue_opa", issue_opa, 0);
        chk("reset_issue_payload", issue_payload, 0);
        @(posedge clock); #1;
        reset = 1'b0; dispatch_valid = '0;

        // Wait on a tag, then wake it from CDB0
        s = lane(idle(), 0, 6, 1'b1, 3, 1'b0);
        cycle(s);
        chk("t1_free_slots", free_slots, 15);
        chk("t1_not_ready", issue_valid, 0);
        s = idle(); s.cv[0] = 1'b1; s.ct[0] = 3; s.cd[0] = 32'habc;
        cycle(s);
        chk("t1_woken_valid", issue_valid, 2'b01);
        chk("t1_woken_opa", issue_opa[31:0], 6);
        chk("t1_woken_opb", issue_opb[31:0], 32'habc);
        s = idle(); s.ir = 2'b01; cycle(s);

        // Three ready lanes drain through two ports, oldest first
        s = idle();
        for (int k = 0; k < W; k++) s = lane(s, k, 32'(100 + k), 1'b1, 32'(200 + k), 1'b1);
        s.ir = 2'b11; cycle(s);
        s = idle(); s.ir = 2'b11; cycle(s);
        s = idle(); s.ir = 2'b11; cycle(s);
        chk("t2_free_slots", free_slots, RS);

        // Fill to one free slot; only lane 0 of the next three fits
        for (int c = 0; c < 5; c++) begin
            s = idle();
            for (int k = 0; k < W; k++) s = lane(s, k, 32'(c * 3 + k), 1'b1, 40, 1'b0);
            cycle(s);
        end
        chk("t3_one_free", free_slots, 1);
        s = idle();
        for (int k = 0; k < W; k++) s = lane(s, k, 32'(50 + k), 1'b1, 40, 1'b0);
        cycle(s);
        chk("t3_full", free_slots, 0);
        s = idle(); s = lane(s, 0, 1, 1'b1, 2, 1'b1); cycle(s);
        s = idle(); s.sq = 1'b1; cycle(s);
        chk("t3_squashed", free_slots, RS);

        // Dispatch-time CDB bypass on channel 1
        s = lane(idle(), 0, 9, 1'b1, 5, 1'b0);
        s.cv[1] = 1'b1; s.ct[1] = 5; s.cd[1] = 32'h77;
        cycle(s);
        chk("t4_bypass_valid", issue_valid, 2'b01);
        chk("t4_bypass_opb", issue_opb[31:0], 32'h77);
        s = idle(); s.ir = 2'b01; cycle(s);

        // Ten busy entries, squash together with a dispatch
        for (int c = 0; c < 4; c++) begin
            s = idle();
            for (int k = 0; k < ((c == 3) ? 1 : 3); k++) s = lane(s, k, 32'(c), 1'b1, 41, 1'b0);
            cycle(s);
        end
        chk("t5_ten_busy", free_slots, 6);
        s = lane(idle(), 0, 3, 1'b1, 4, 1'b1); s.sq = 1'b1; cycle(s);
        chk("t5_free_slots", free_slots, RS);
        chk("t5_issue_valid", issue_valid, 0);
        cycle(idle());

        // Held issue: outputs stay put until ready rises
        s = lane(idle(), 1, 32'h1234, 1'b1, 32'h5678, 1'b1); cycle(s);
        for (int c = 0; c < 3; c++) cycle(idle());
        s = idle(); s.ir = 2'b01; cycle(s);
        chk("t6_freed", free_slots, RS);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cycle(rand_stim());
        end
        cycle(idle());
        @(negedge clock); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
